// File: rtl/bp_me_irq_gateway.sv
// bp_me_irq_gateway
//   External interrupt gateway feeding the CLINT slice's PLIC bits. Each
//   source is synchronized, latched as pending (edge or level mode) and
//   serviced through a claim/complete handshake. The OR of pending & enable
//   per privilege level is mirrored into the CLINT by 64-bit register writes.
//   The M-mode level goes to plic_base_addr_p and the S-mode level goes to
//   plic_base_addr_p+8.
//
// Ports
//   clk_i, reset_n_i         clock, asynchronous active-low reset
//   src_i                    raw interrupt sources (asynchronous)
//   cfg_w_v_i/sel_i/data_i   config write: 0=enable_m 1=enable_s 2=edge_mode
//                            3=drop counter clear
//   claim_v_i                claim request; claim_hit_o/claim_id_o answer
//                            combinationally in the same cycle
//   complete_v_i/id_i        end of service for one source
//   wr_v_o/addr_o/data_o     write command (valid/ready), wr_ready_and_i
//   drop_cnt_o               saturating count of dropped edges (optional)
//
// Optional feature: define BP_ME_IRQ_GW_DROP_CNT_EN to add drop_cnt_o.
// Without it, cfg_sel_i=3 writes are ignored.

// Per-source lane: synchronizer, edge detect, pending and in-service bits.
module bp_me_irq_gateway_src (
  input  logic clk,
  input  logic rst_n,
  input  logic src_raw,
  input  logic edge_mode,
  input  logic claim,
  input  logic complete,
  output logic pending,
  output logic in_service,
  output logic drop
);
  logic sync_q, src_s, src_d;
  logic rise, trig, busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 1'b0;
      src_s  <= 1'b0;
      src_d  <= 1'b0;
    end else begin
      sync_q <= src_raw;
      src_s  <= sync_q;
      src_d  <= src_s;
    end
  end

  assign rise = src_s & ~src_d;
  assign trig = edge_mode ? rise : src_s;
  // A completion in this cycle reopens the source immediately, so an edge or
  // level arriving alongside it is not lost.
  assign busy = in_service & ~complete;
  assign drop = edge_mode & rise & busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending    <= 1'b0;
      in_service <= 1'b0;
    end else begin
      if (claim)              pending <= 1'b0;
      else if (trig && !busy) pending <= 1'b1;

      if (claim)         in_service <= 1'b1;
      else if (complete) in_service <= 1'b0;
    end
  end
endmodule

module bp_me_irq_gateway #(
  parameter int num_src_p        = 8,
  parameter int dev_addr_width_p = 20,
  parameter logic [dev_addr_width_p-1:0] plic_base_addr_p = 20'h0B000
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic [num_src_p-1:0]         src_i,
  input  logic                         cfg_w_v_i,
  input  logic [1:0]                   cfg_sel_i,
  input  logic [num_src_p-1:0]         cfg_data_i,
  input  logic                         claim_v_i,
  output logic                         claim_hit_o,
  output logic [$clog2(num_src_p)-1:0] claim_id_o,
  input  logic                         complete_v_i,
  input  logic [$clog2(num_src_p)-1:0] complete_id_i,
  output logic                         wr_v_o,
  output logic [dev_addr_width_p-1:0]  wr_addr_o,
  output logic [63:0]                  wr_data_o,
  input  logic                         wr_ready_and_i
`ifdef BP_ME_IRQ_GW_DROP_CNT_EN
  ,
  output logic [7:0]                   drop_cnt_o
`endif
);
  localparam int id_w = $clog2(num_src_p);
  localparam logic [dev_addr_width_p-1:0] plic_s_addr =
    plic_base_addr_p + dev_addr_width_p'(8);

  typedef enum logic [1:0] {IDLE, SEND_M, SEND_S} state_e;

  logic [num_src_p-1:0] enable_m, enable_s, edge_mode;
  logic [num_src_p-1:0] pending, in_service, drop;
  logic [num_src_p-1:0] eligible, claim_sel, comp_sel;
  logic [id_w-1:0]      claim_idx;
  logic                 found;
  logic                 m_want, s_want;

  state_e state, state_n;
  logic   cap, cap_n, m_sent, m_sent_n, s_sent, s_sent_n;

  // ---------------- config registers ----------------
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      enable_m  <= '0;
      enable_s  <= '0;
      edge_mode <= '0;
    end else if (cfg_w_v_i) begin
      case (cfg_sel_i)
        2'd0:    enable_m  <= cfg_data_i;
        2'd1:    enable_s  <= cfg_data_i;
        2'd2:    edge_mode <= cfg_data_i;
        default: ;
      endcase
    end
  end

  // ---------------- per-source lanes ----------------
  for (genvar i = 0; i < num_src_p; i++) begin : g_src
    // Indices at or above num_src_p match no lane, so such completes vanish.
    assign claim_sel[i] = claim_hit_o && (claim_idx == id_w'(i));
    assign comp_sel[i]  = complete_v_i && (complete_id_i == id_w'(i));

    bp_me_irq_gateway_src u_src (
      .clk        (clk_i),
      .rst_n      (reset_n_i),
      .src_raw    (src_i[i]),
      .edge_mode  (edge_mode[i]),
      .claim      (claim_sel[i]),
      .complete   (comp_sel[i]),
      .pending    (pending[i]),
      .in_service (in_service[i]),
      .drop       (drop[i])
    );
  end

  // ---------------- claim: lowest-index eligible source ----------------
  assign eligible = pending & (enable_m | enable_s);

  always_comb begin
    claim_idx = '0;
    found     = 1'b0;
    for (int i = num_src_p - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        claim_idx = id_w'(i);
        found     = 1'b1;
      end
    end
  end

  assign claim_hit_o = claim_v_i & found;
  assign claim_id_o  = claim_hit_o ? claim_idx : '0;

  // ---------------- write command FSM ----------------
  assign m_want = |(pending & enable_m);
  assign s_want = |(pending & enable_s);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state  <= IDLE;
      cap    <= 1'b0;
      m_sent <= 1'b0;
      s_sent <= 1'b0;
    end else begin
      state  <= state_n;
      cap    <= cap_n;
      m_sent <= m_sent_n;
      s_sent <= s_sent_n;
    end
  end

  // The level is captured on leaving IDLE, so addr/data stay frozen while a
  // write waits for ready. Any change in the meantime is caught on return to
  // IDLE and produces a follow-up write.
  always_comb begin
    state_n   = state;
    cap_n     = cap;
    m_sent_n  = m_sent;
    s_sent_n  = s_sent;
    wr_v_o    = 1'b0;
    wr_addr_o = '0;
    wr_data_o = '0;
    case (state)
      IDLE: begin
        if (m_want != m_sent) begin
          cap_n   = m_want;
          state_n = SEND_M;
        end else if (s_want != s_sent) begin
          cap_n   = s_want;
          state_n = SEND_S;
        end
      end
      SEND_M: begin
        wr_v_o    = 1'b1;
        wr_addr_o = plic_base_addr_p;
        wr_data_o = {63'b0, cap};
        if (wr_ready_and_i) begin
          m_sent_n = cap;
          state_n  = IDLE;
        end
      end
      SEND_S: begin
        wr_v_o    = 1'b1;
        wr_addr_o = plic_s_addr;
        wr_data_o = {63'b0, cap};
        if (wr_ready_and_i) begin
          s_sent_n = cap;
          state_n  = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // ---------------- optional dropped-edge counter ----------------
`ifdef BP_ME_IRQ_GW_DROP_CNT_EN
  logic [5:0] drop_pop;
  logic [8:0] drop_sum;
  logic       drop_clr;

  always_comb begin
    drop_pop = '0;
    for (int i = 0; i < num_src_p; i++) drop_pop = drop_pop + 6'(drop[i]);
  end

  assign drop_sum = {1'b0, drop_cnt_o} + {3'b0, drop_pop};
  assign drop_clr = cfg_w_v_i && (cfg_sel_i == 2'd3);

  // A clear wins over drops counted in the same cycle.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)          drop_cnt_o <= '0;
    else if (drop_clr)       drop_cnt_o <= '0;
    else if (drop_sum > 255) drop_cnt_o <= 8'hFF;
    else                     drop_cnt_o <= drop_sum[7:0];
  end
`else
  logic unused_drop;
  assign unused_drop = |drop;
`endif
endmodule
